// File: rtl/seq_detect_param.sv
// Serial pattern detector: runtime-programmable 1..MAX_LEN bit pattern,
// overlapping or non-overlapping matches, registered match pulse and saturating count.
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN+1),
  parameter int CNT_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_din_valid,
  input  logic               i_din,
  input  logic [MAX_LEN-1:0] i_pat,
  input  logic [LEN_W-1:0]   i_pat_len,
  input  logic               i_overlap_en,
  input  logic               i_clr,
  output logic               o_y,
  output logic [CNT_W-1:0]   o_match_cnt,
  output logic               o_cnt_sat
);

  localparam logic [LEN_W:0]   LEN_MAX  = (LEN_W+1)'(MAX_LEN);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_y;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;

  logic [MAX_LEN-1:0] w_win;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W:0]     w_len;
  logic [LEN_W:0]     w_fill_inc;
  logic               w_len_ok;
  logic               w_match;
  logic [CNT_W-1:0]   w_cnt_nxt;

  assign w_win      = {r_hist[MAX_LEN-2:0], i_din};
  assign w_len      = {1'b0, i_pat_len};
  assign w_fill_inc = {1'b0, r_fill} + 1'b1;
  assign w_len_ok   = (i_pat_len != '0) && (w_len <= LEN_MAX);

  // Only the low pat_len bits of the window take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < MAX_LEN; k++)
      w_mask[k] = (w_len > (LEN_W+1)'(k));
  end

  assign w_match   = w_len_ok && (w_fill_inc >= w_len) &&
                     (((w_win ^ i_pat) & w_mask) == '0);
  assign w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
    end else begin
      r_y <= i_din_valid && w_match;
      if (i_din_valid) begin
        // Non-overlap mode discards the bits of the completed match.
        if (w_match && !i_overlap_en) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_win;
          r_fill <= (r_fill == FILL_MAX) ? r_fill : w_fill_inc[LEN_W-1:0];
        end
        if (w_match) begin
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == '1) r_sat <= 1'b1;
        end
      end
    end
  end

  assign o_y         = r_y;
  assign o_match_cnt = r_cnt;
  assign o_cnt_sat   = r_sat;

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial pattern detector, successor to the fixed 4-bit Mealy detector.
- Watches a qualified serial bit stream for a runtime-programmable pattern of 1..MAX_LEN bits.
- Supports overlapping and non-overlapping detection, with a registered 1-cycle match pulse and a saturating match counter.
- Sits between a serial front-end (bit-valid strobe) and status/CSR logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1), width of pat_len.
- CNT_W, 8, width of match counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- din_valid  input  1  din is sampled only when high.
- din  input  1  serial data bit.
- pat  input  MAX_LEN  pattern; pat[pat_len-1] is the first (oldest) bit, pat[0] is the last (newest) bit.
- pat_len  input  LEN_W  active pattern length; legal range 1..MAX_LEN.
- overlap_en  input  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- clr  input  1  synchronous clear of history, counter and flags.
- y  output  1  1-cycle match pulse.
- match_cnt  output  CNT_W  number of matches since reset/clr, saturating.
- cnt_sat  output  1  sticky, set when match_cnt reaches all-ones.

Behaviour:
- Reset (rst_n low at posedge): hist=0, fill=0, y=0, match_cnt=0, cnt_sat=0. Reset overrides clr and din_valid.
- Internal state:
  - hist[MAX_LEN-1:0], shift register; hist[0] holds the newest accepted bit.
  - fill, count of valid history bits, range 0..MAX_LEN, saturates at MAX_LEN.
- Accepted bit: din_valid=1, clr=0, rst_n=1.
- Match condition, evaluated combinationally on an accepted bit:
  - Candidate window w = {hist[MAX_LEN-2:0], din}.
  - Match when pat_len is legal, (fill+1) >= pat_len, and w[pat_len-1:0] == pat[pat_len-1:0].
- Output timing:
  - y is registered: high for exactly one cycle, the cycle after the posedge that accepted the completing bit (same latency as the existing Mealy detector with registered y).
  - y=0 in every other cycle, including cycles with din_valid=0.
- Update on an accepted bit:
  - No match, or match with overlap_en=1: hist <= {hist[MAX_LEN-2:0], din}; fill <= min(fill+1, MAX_LEN).
  - Match with overlap_en=0: hist <= 0; fill <= 0. The next match must use entirely new bits.
- din_valid=0: hist, fill and match_cnt hold; y <= 0.
- Counter:
  - On each match, match_cnt <= match_cnt+1 unless already all-ones. Then it holds at all-ones and cnt_sat <= 1.
  - cnt_sat stays set until clr or reset.
- clr=1 (rst_n high): hist=0, fill=0, match_cnt=0, cnt_sat=0, y<=0. A din presented in the same cycle is dropped, not counted.
- Illegal pat_len (0 or >MAX_LEN): never matches, y stays 0; history still shifts and fill still counts.
- Configuration inputs (pat, pat_len, overlap_en) are sampled on every accepted bit. A change takes effect on the next accepted bit. History is not flushed automatically; software issues clr if needed.
- pat_len=1: every accepted bit equal to pat[0] matches. With overlap_en=0, fill clears each match with no functional effect.
- No combinational path from any input to y, match_cnt or cnt_sat.

Test Plan:
- Overlap: pat=8'b0000_1101, pat_len=4, overlap_en=1, valid stream 1,1,0,1,1,0,1 -> y pulses the cycle after bit 4 and after bit 7; match_cnt=2.
- Non-overlap: same stream with overlap_en=0 -> single y pulse after bit 4; match_cnt=1; the trailing 1,0,1 does not match.
- Gaps and length: pat_len=8, pat=8'hA5, bits 1,0,1,0,0,1,0,1 with din_valid low for 3 cycles between bits 2 and 3 -> one pulse after bit 8; no pulses during gaps; match_cnt=1.
- Saturation: CNT_W=3, pat_len=1, pat[0]=1, 9 consecutive valid 1s with overlap_en=1 -> match_cnt sticks at 7 after the 7th bit, cnt_sat=1; clr -> match_cnt=0, cnt_sat=0, y=0.
- Reset mid-match: pat 1101, feed 1,1,0, hold rst_n=0 one cycle, then feed 1 -> no pulse; fresh 1,1,0,1 -> pulse.
- Edge cases:
  - pat_len=0 with any stream -> y never asserts, match_cnt=0.
  - clr asserted together with the completing bit -> no pulse, bit dropped.
